spi_arbiter: RTL and testbench

- Shares the single SPI master between three requesters: req0 = command/config (digital pots, trigger level), req1 = dump state machine (gain/offset pot writes), req2 = EEPROM calibration reads.
- Round-robin grant; launches one transaction per grant with a 1-clock wrt_SPI pulse; holds ss/SPI_data stable until SPI_done.
- Returns the captured EEP_data byte plus a done pulse to the owner.
- A timeout guards against a hung SPI peripheral.

---
 rtl/spi_arbiter.sv | 166 ++++++++++++++++
 tb/tb_spi_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between three requesters.
// One transaction per grant: launch pulse, wait for SPI_done or timeout, then done/err pulse.
module spi_arbiter #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = 10
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_req,
    input  logic [15:0] req0_data,
    input  logic [2:0]  req0_ss,
    output logic        req0_done,
    output logic        req0_err,

    input  logic        req1_req,
    input  logic [15:0] req1_data,
    input  logic [2:0]  req1_ss,
    output logic        req1_done,
    output logic        req1_err,

    input  logic        req2_req,
    input  logic [15:0] req2_data,
    input  logic [2:0]  req2_ss,
    output logic        req2_done,
    output logic        req2_err,

    output logic [7:0]  rd_data,
    output logic [15:0] SPI_data,
    output logic [2:0]  ss,
    output logic        wrt_SPI,
    input  logic        SPI_done,
    input  logic [7:0]  EEP_data,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]      r_state;
    logic [15:0]     r_spi_data;
    logic [2:0]      r_ss;
    logic [1:0]      r_grant;
    logic [1:0]      r_last;
    logic [TO_W-1:0] r_cnt;
    logic            r_err;
    logic [7:0]      r_rd_data;

    logic [2:0]      w_req;
    logic [15:0]     w_data [3];
    logic [2:0]      w_ss   [3];
    logic [1:0]      w_cand [3];
    logic            w_any;
    logic [1:0]      w_win;
    logic [2:0]      w_done;
    logic [2:0]      w_err;
    logic            w_timeout;

    // Index of the requester that sits 'off' places after 'last' in the 0->1->2 ring.
    function automatic logic [1:0] rr_idx(input logic [1:0] last, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, last} + {1'b0, off};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    assign w_req     = {req2_req, req1_req, req0_req};
    assign w_data[0] = req0_data;
    assign w_data[1] = req1_data;
    assign w_data[2] = req2_data;
    assign w_ss[0]   = req0_ss;
    assign w_ss[1]   = req1_ss;
    assign w_ss[2]   = req2_ss;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cand
            assign w_cand[gi] = rr_idx(r_last, 2'(gi + 1));
        end
    endgenerate

    // Scan from the lowest priority upward so the requester right after r_last wins.
    always_comb begin
        w_any = 1'b0;
        w_win = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            if (w_req[w_cand[k-1]]) begin
                w_any = 1'b1;
                w_win = w_cand[k-1];
            end
        end
    end

    assign w_timeout = (r_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_spi_data <= 16'h0000;
            r_ss       <= 3'b000;
            r_grant    <= 2'd0;
            r_last     <= 2'd2;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_spi_data <= w_data[w_win];
                        r_ss       <= w_ss[w_win];
                        r_grant    <= w_win;
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A completion in the expiry cycle still counts as success.
                    if (SPI_done) begin
                        r_rd_data <= EEP_data;
                        r_state   <= DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_last  <= r_grant;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_done
            assign w_done[gi] = (r_state == DONE) && (r_grant == 2'(gi));
            assign w_err[gi]  = w_done[gi] && r_err;
        end
    endgenerate

    assign req0_done = w_done[0];
    assign req1_done = w_done[1];
    assign req2_done = w_done[2];
    assign req0_err  = w_err[0];
    assign req1_err  = w_err[1];
    assign req2_err  = w_err[2];

    assign rd_data  = r_rd_data;
    assign SPI_data = r_spi_data;
    assign ss       = r_ss;
    assign wrt_SPI  = (r_state == LAUNCH);
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: single grant, round-robin order, fairness, timeout, ignored inputs, reset.
module tb_spi_arbiter;

    localparam int TIMEOUT_CYC = 1024;

    logic        clk;
    logic        rst_n;
    logic        req0_req, req1_req, req2_req;
    logic [15:0] req0_data, req1_data, req2_data;
    logic [2:0]  req0_ss, req1_ss, req2_ss;
    logic        req0_done, req1_done, req2_done;
    logic        req0_err, req1_err, req2_err;
    logic [7:0]  rd_data;
    logic [15:0] SPI_data;
    logic [2:0]  ss;
    logic        wrt_SPI;
    logic        SPI_done;
    logic [7:0]  EEP_data;
    logic        busy;

    int n_run  = 0;
    int n_fail = 0;

    logic [2:0] done_v;
    logic [2:0] err_v;
    assign done_v = {req2_done, req1_done, req0_done};
    assign err_v  = {req2_err, req1_err, req0_err};

    spi_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_req(req0_req), .req0_data(req0_data), .req0_ss(req0_ss),
        .req0_done(req0_done), .req0_err(req0_err),
        .req1_req(req1_req), .req1_data(req1_data), .req1_ss(req1_ss),
        .req1_done(req1_done), .req1_err(req1_err),
        .req2_req(req2_req), .req2_data(req2_data), .req2_ss(req2_ss),
        .req2_done(req2_done), .req2_err(req2_err),
        .rd_data(rd_data), .SPI_data(SPI_data), .ss(ss), .wrt_SPI(wrt_SPI),
        .SPI_done(SPI_done), .EEP_data(EEP_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_launch(input string tag);
        for (int i = 0; i < 20 && !wrt_SPI; i++) step();
        chk(tag, {15'd0, wrt_SPI}, 16'd1);
    endtask

    // Wait for the launch, confirm the granted word, complete the transfer and check the done pulse.
    task automatic serve(input string tag, input int idx, input logic [15:0] exp_d,
                         input logic [7:0] eep, input bit drop);
        wait_launch({tag, "_launch"});
        chk({tag, "_grant"}, SPI_data, exp_d);
        step();
        SPI_done = 1'b1;
        EEP_data = eep;
        step();
        SPI_done = 1'b0;
        chk({tag, "_done"}, {13'd0, done_v}, 16'(1 << idx));
        chk({tag, "_rd"}, {8'd0, rd_data}, {8'd0, eep});
        if (drop) begin
            case (idx)
                0: req0_req = 1'b0;
                1: req1_req = 1'b0;
                default: req2_req = 1'b0;
            endcase
        end
        step();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        req0_req  = 1'b0; req1_req = 1'b0; req2_req = 1'b0;
        req0_data = 16'h1111; req0_ss = 3'b001;
        req1_data = 16'h2222; req1_ss = 3'b010;
        req2_data = 16'h3333; req2_ss = 3'b100;
        SPI_done  = 1'b0;
        EEP_data  = 8'h00;

        // Reset state
        step(); step(); step();
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_wrt", {15'd0, wrt_SPI}, 16'd0);
        chk("rst_spidata", SPI_data, 16'h0000);
        chk("rst_ss", {13'd0, ss}, 16'd0);
        chk("rst_rd", {8'd0, rd_data}, 16'd0);
        chk("rst_done", {13'd0, done_v}, 16'd0);
        rst_n = 1'b1;
        step();

        // Single request on req1
        req1_req = 1'b1; req1_data = 16'hA5C3; req1_ss = 3'b010;
        step();
        chk("t1_wrt", {15'd0, wrt_SPI}, 16'd1);
        chk("t1_data", SPI_data, 16'hA5C3);
        chk("t1_ss", {13'd0, ss}, 16'h0002);
        chk("t1_busy", {15'd0, busy}, 16'd1);
        step();
        chk("t1_wrt_off", {15'd0, wrt_SPI}, 16'd0);
        req1_data = 16'h0000;
        step(); step();
        chk("t1_data_hold", SPI_data, 16'hA5C3);
        chk("t1_ss_hold", {13'd0, ss}, 16'h0002);
        chk("t1_nodone", {13'd0, done_v}, 16'd0);
        SPI_done = 1'b1; EEP_data = 8'h5A;
        step();
        SPI_done = 1'b0;
        chk("t1_done", {13'd0, done_v}, 16'b010);
        chk("t1_err", {13'd0, err_v}, 16'd0);
        chk("t1_rd", {8'd0, rd_data}, 16'h005A);
        req1_req = 1'b0;
        step();
        chk("t1_idle", {15'd0, busy}, 16'd0);
        chk("t1_ss_idle", {13'd0, ss}, 16'h0002);
        req1_data = 16'h2222;

        // Three simultaneous requests from a fresh reset: 0, 1, 2; then 0, 2
        pulse_reset();
        req0_req = 1'b1; req1_req = 1'b1; req2_req = 1'b1;
        serve("t2a", 0, 16'h1111, 8'h10, 1'b1);
        serve("t2b", 1, 16'h2222, 8'h20, 1'b1);
        serve("t2c", 2, 16'h3333, 8'h30, 1'b1);
        req0_req = 1'b1; req2_req = 1'b1;
        serve("t2d", 0, 16'h1111, 8'h40, 1'b1);
        serve("t2e", 2, 16'h3333, 8'h50, 1'b1);

        // Fairness: req0 held throughout, req2 still gets in between
        req0_req = 1'b1; req2_req = 1'b1;
        serve("t3a", 0, 16'h1111, 8'h60, 1'b0);
        serve("t3b", 2, 16'h3333, 8'h70, 1'b1);
        serve("t3c", 0, 16'h1111, 8'h80, 1'b1);

        // Timeout on req2
        req2_req = 1'b1;
        wait_launch("t4_launch");
        k = 0;
        while (!req2_done && k < TIMEOUT_CYC + 50) begin
            step();
            k++;
        end
        chk("t4_latency", 16'(k), 16'(TIMEOUT_CYC + 1));
        chk("t4_err", {13'd0, err_v}, 16'b100);
        chk("t4_rd_kept", {8'd0, rd_data}, 16'h0080);
        req2_req = 1'b0;
        step();
        chk("t4_busy", {15'd0, busy}, 16'd0);
        chk("t4_err_off", {13'd0, err_v}, 16'd0);

        // SPI_done while idle is ignored; data change during WAIT is ignored
        SPI_done = 1'b1; EEP_data = 8'hEE;
        step();
        SPI_done = 1'b0;
        chk("t5_idle_done", {13'd0, done_v}, 16'd0);
        chk("t5_idle_busy", {15'd0, busy}, 16'd0);
        chk("t5_idle_rd", {8'd0, rd_data}, 16'h0080);
        req0_req = 1'b1; req0_data = 16'h1234;
        wait_launch("t5_launch");
        step();
        req0_data = 16'hFFFF;
        step();
        chk("t5_data_hold", SPI_data, 16'h1234);
        SPI_done = 1'b1; EEP_data = 8'hC3;
        step();
        SPI_done = 1'b0;
        chk("t5_done", {13'd0, done_v}, 16'b001);
        chk("t5_rd", {8'd0, rd_data}, 16'h00C3);
        req0_req = 1'b0; req0_data = 16'h1111;
        step();

        // Asynchronous reset mid-WAIT
        req1_req = 1'b1;
        wait_launch("t6_launch");
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", {15'd0, busy}, 16'd0);
        chk("t6_wrt", {15'd0, wrt_SPI}, 16'd0);
        chk("t6_spidata", SPI_data, 16'h0000);
        chk("t6_ss", {13'd0, ss}, 16'd0);
        chk("t6_rd", {8'd0, rd_data}, 16'd0);
        req0_req = 1'b1;
        step();
        chk("t6_nodone", {13'd0, done_v}, 16'd0);
        rst_n = 1'b1;
        serve("t6a", 0, 16'h1111, 8'h99, 1'b1);
        serve("t6b", 1, 16'h2222, 8'h77, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
